// File: rtl/br_amba_apb_arb.sv
// Round-robin arbiter sharing one APB completer between several APB requesters.
// One transfer in flight; the granted request is replayed downstream as Setup/Access.
module br_amba_apb_arb #(
    parameter int NumRequesters = 2,
    parameter int AddrWidth     = 12,
    parameter int DataWidth     = 32,
    localparam int ApbProtWidth = 3,
    localparam int StrbWidth    = DataWidth / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NumRequesters*AddrWidth-1:0]    req_paddr,
    input  logic [NumRequesters-1:0]              req_psel,
    input  logic [NumRequesters-1:0]              req_penable,
    input  logic [NumRequesters*ApbProtWidth-1:0] req_pprot,
    input  logic [NumRequesters*StrbWidth-1:0]    req_pstrb,
    input  logic [NumRequesters-1:0]              req_pwrite,
    input  logic [NumRequesters*DataWidth-1:0]    req_pwdata,
    output logic [DataWidth-1:0]                  req_prdata,
    output logic [NumRequesters-1:0]              req_pready,
    output logic [NumRequesters-1:0]              req_pslverr,
    output logic [AddrWidth-1:0]                  paddr,
    output logic                                  psel,
    output logic                                  penable,
    output logic [ApbProtWidth-1:0]               pprot,
    output logic [StrbWidth-1:0]                  pstrb,
    output logic                                  pwrite,
    output logic [DataWidth-1:0]                  pwdata,
    input  logic [DataWidth-1:0]                  prdata,
    input  logic                                  pready,
    input  logic                                  pslverr
);

    localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    typedef enum logic [2:0] {
        Idle   = 3'b001,
        Setup  = 3'b010,
        Access = 3'b100
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] rr_idx;
    logic            rr_found;

    logic [AddrWidth-1:0]    g_paddr;
    logic [ApbProtWidth-1:0] g_pprot;
    logic [StrbWidth-1:0]    g_pstrb;
    logic                    g_pwrite;
    logic [DataWidth-1:0]    g_pwdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Idle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < NumRequesters; k++) begin
            cand     = (int'(ptr_q) + k) % NumRequesters;
            cand_idx = IdxW'(cand);
            if (!rr_found && req_psel[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        psel        = 1'b0;
        penable     = 1'b0;
        req_pready  = '0;
        req_pslverr = '0;
        unique case (state_q)
            Idle: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    state_d = Setup;
                end
            end
            Setup: begin
                psel    = 1'b1;
                state_d = Access;
            end
            Access: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    req_pready[grant_q]  = 1'b1;
                    req_pslverr[grant_q] = pslverr;
                    ptr_d   = (grant_q == IdxW'(NumRequesters - 1)) ? '0 : grant_q + 1'b1;
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Requests are forwarded live; APB holds them stable until completion.
    assign g_paddr  = req_paddr[grant_q*AddrWidth +: AddrWidth];
    assign g_pprot  = req_pprot[grant_q*ApbProtWidth +: ApbProtWidth];
    assign g_pstrb  = req_pstrb[grant_q*StrbWidth +: StrbWidth];
    assign g_pwrite = req_pwrite[grant_q];
    assign g_pwdata = req_pwdata[grant_q*DataWidth +: DataWidth];

    assign paddr      = psel ? g_paddr  : '0;
    assign pprot      = psel ? g_pprot  : '0;
    assign pstrb      = psel ? g_pstrb  : '0;
    assign pwrite     = psel ? g_pwrite : 1'b0;
    assign pwdata     = psel ? g_pwdata : '0;
    assign req_prdata = prdata;

    a_pready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_pready));

    a_grant_held: assert property (@(posedge clk) disable iff (rst)
        (state_q != Idle) |-> (req_psel[grant_q] && req_penable[grant_q]));

    a_fields_stable: assert property (@(posedge clk) disable iff (rst)
        ((state_q == Setup) || (state_q == Access && !pready))
        |=> $stable({g_paddr, g_pprot, g_pstrb, g_pwrite, g_pwdata}));

    a_state_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(state_q));

endmodule

// File: tb/tb_br_amba_apb_arb.sv
// Randomized bench for br_amba_apb_arb: APB requester and completer models
// with a transaction-level round-robin reference model.
module tb_br_amba_apb_arb;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int PW = 3;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*AW-1:0] req_paddr;
    logic [N-1:0]    req_psel, req_penable, req_pwrite;
    logic [N*PW-1:0] req_pprot;
    logic [N*SW-1:0] req_pstrb;
    logic [N*DW-1:0] req_pwdata;
    logic [DW-1:0]   req_prdata;
    logic [N-1:0]    req_pready, req_pslverr;
    logic [AW-1:0]   paddr;
    logic            psel, penable, pwrite;
    logic [PW-1:0]   pprot;
    logic [SW-1:0]   pstrb;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready, pslverr;

    logic [AW-1:0] r_addr [N];
    logic [PW-1:0] r_prot [N];
    logic [SW-1:0] r_strb [N];
    logic [DW-1:0] r_wdata[N];
    logic [N-1:0]  r_psel, r_pen, r_write;

    always_comb begin
        req_paddr  = '0;
        req_pprot  = '0;
        req_pstrb  = '0;
        req_pwdata = '0;
        for (int i = 0; i < N; i++) begin
            req_paddr[i*AW +: AW]  = r_addr[i];
            req_pprot[i*PW +: PW]  = r_prot[i];
            req_pstrb[i*SW +: SW]  = r_strb[i];
            req_pwdata[i*DW +: DW] = r_wdata[i];
        end
        req_psel    = r_psel;
        req_penable = r_pen;
        req_pwrite  = r_write;
    end

    br_amba_apb_arb #(.NumRequesters(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk(clk), .rst(rst),
        .req_paddr(req_paddr), .req_psel(req_psel), .req_penable(req_penable),
        .req_pprot(req_pprot), .req_pstrb(req_pstrb), .req_pwrite(req_pwrite),
        .req_pwdata(req_pwdata), .req_prdata(req_prdata), .req_pready(req_pready),
        .req_pslverr(req_pslverr), .paddr(paddr), .psel(psel), .penable(penable),
        .pprot(pprot), .pstrb(pstrb), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase of the current transfer, grantee, rotating priority.
    int m_phase, m_g, m_ptr, wait_cnt, rate;
    int completions[N];
    logic [N-1:0] done;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] reqs);
        for (int k = 0; k < N; k++)
            if (reqs[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic clear_requesters();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_prot[i] = '0; r_strb[i] = '0; r_wdata[i] = '0;
        end
        r_psel = '0; r_pen = '0; r_write = '0;
    endtask

    task automatic check_fields(input string ph);
        chk({ph, "_paddr"},  paddr,  r_addr[m_g]);
        chk({ph, "_pprot"},  pprot,  r_prot[m_g]);
        chk({ph, "_pstrb"},  pstrb,  r_strb[m_g]);
        chk({ph, "_pwrite"}, pwrite, r_write[m_g]);
        chk({ph, "_pwdata"}, pwdata, r_wdata[m_g]);
    endtask

    task automatic tb_cycle();
        logic [N-1:0] exp_rdy, exp_err;
        @(negedge clk);
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        if (psel && !penable) wait_cnt = $urandom_range(0, 5);
        if (psel && penable) begin
            pready = (wait_cnt == 0);
            if (wait_cnt > 0) wait_cnt--;
        end else begin
            pready = 1'($urandom_range(0, 1));
        end
        #1;
        done    = '0;
        exp_rdy = '0;
        exp_err = '0;
        case (m_phase)
            0: begin
                chk("idle_psel", psel, 1'b0);
                chk("idle_penable", penable, 1'b0);
                chk("idle_paddr", paddr, '0);
                chk("idle_pwdata", pwdata, '0);
                chk("idle_pwrite", pwrite, 1'b0);
                chk("idle_pstrb", pstrb, '0);
                chk("idle_pready", req_pready, '0);
                chk("idle_pslverr", req_pslverr, '0);
                if (|r_psel) begin
                    m_g     = rr_pick(m_ptr, r_psel);
                    m_phase = 1;
                end
            end
            1: begin
                chk("setup_psel", psel, 1'b1);
                chk("setup_penable", penable, 1'b0);
                chk("setup_pready", req_pready, '0);
                check_fields("setup");
                m_phase = 2;
            end
            default: begin
                chk("access_psel", psel, 1'b1);
                chk("access_penable", penable, 1'b1);
                check_fields("access");
                if (pready) begin
                    exp_rdy[m_g] = 1'b1;
                    exp_err[m_g] = pslverr;
                    chk("done_prdata", req_prdata, prdata);
                    done[m_g] = 1'b1;
                    completions[m_g]++;
                    m_ptr   = (m_g + 1) % N;
                    m_phase = 0;
                end
                chk("access_pready", req_pready, exp_rdy);
                chk("access_pslverr", req_pslverr, exp_err);
            end
        endcase
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                r_psel[i] = 1'b0;
                r_pen[i]  = 1'b0;
            end else if (r_psel[i] && !r_pen[i]) begin
                r_pen[i] = 1'b1;
            end else if (!r_psel[i] && $urandom_range(0, 99) < rate) begin
                r_psel[i]  = 1'b1;
                r_pen[i]   = 1'b0;
                r_addr[i]  = AW'($urandom);
                r_prot[i]  = PW'($urandom);
                r_strb[i]  = SW'($urandom);
                r_write[i] = 1'($urandom_range(0, 1));
                r_wdata[i] = $urandom;
            end
        end
    endtask

    initial begin
        logic         reached;
        logic [N-1:0] exp_rdy;
        rst = 1'b1;
        clear_requesters();
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        m_phase = 0; m_g = 0; m_ptr = 0; wait_cnt = 0; rate = 0;
        for (int i = 0; i < N; i++) completions[i] = 0;
        repeat (2) @(negedge clk);
        pready = 1'b1;
        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_req_pready", req_pready, '0);
        chk("rst_req_pslverr", req_pslverr, '0);
        chk("rst_paddr", paddr, '0);
        @(negedge clk);
        rst = 1'b0;

        rate = 100; repeat (600) tb_cycle();
        rate = 30;  repeat (600) tb_cycle();
        rate = 5;   repeat (400) tb_cycle();

        // Abandon a transfer by resetting while it sits in Access.
        rate = 100;
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tb_cycle();
            if (m_phase == 2) reached = 1'b1;
        end
        chk("reach_access", reached, 1'b1);
        if (reached) begin
            #1 pready = 1'b1;
            #1;
            exp_rdy = '0;
            exp_rdy[m_g] = 1'b1;
            chk("pre_rst_pready", req_pready, exp_rdy);
            rst = 1'b1;
            #1;
            chk("midrst_psel", psel, 1'b0);
            chk("midrst_penable", penable, 1'b0);
            chk("midrst_req_pready", req_pready, '0);
            chk("midrst_req_pslverr", req_pslverr, '0);
        end
        rst = 1'b1;
        clear_requesters();
        pready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_phase = 0; m_ptr = 0; wait_cnt = 0;

        rate = 100; repeat (300) tb_cycle();
        rate = 40;  repeat (300) tb_cycle();

        for (int i = 0; i < N; i++)
            chk($sformatf("served_req%0d", i), completions[i] > 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
